// File: rtl/wembley_stream_if.sv
// wembley_stream_if
//   Bundles the word-input handshake and the bit-serial output of wembley_stream.
//   master : operand source / serial consumer side (drives in_valid, operands, mode)
//   slave  : wembley_stream side (drives in_ready, Yout, y_valid, y_last, busy)
//   Signals:
//     in_valid / in_ready  word handshake, transfer when both high at a rising edge
//     Ain, Bin, Cin        WIDTH-bit operands
//     mode                 2-bit function select travelling with the word
//     Yout                 serial result bit, LSB first
//     y_valid / y_last     bit strobe / final-bit (MSB) strobe
//     busy                 FIFO non-empty or a word is being shifted out
interface wembley_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] Cin;
    logic [1:0]       mode;
    logic             Yout;
    logic             y_valid;
    logic             y_last;
    logic             busy;

    modport master (
        output in_valid, Ain, Bin, Cin, mode,
        input  in_ready, Yout, y_valid, y_last, busy
    );

    modport slave (
        input  in_valid, Ain, Bin, Cin, mode,
        output in_ready, Yout, y_valid, y_last, busy
    );
endinterface

// File: rtl/wembley_stream.sv
// wembley_stream
//   Accepts operand triples (A, B, C) with a per-word function select, buffers
//   them in a DEPTH-entry FIFO, evaluates the selected function on the FIFO head
//   and shifts the WIDTH-bit result out LSB-first on Yout with framing strobes.
//   Consecutive buffered words are emitted with no idle cycle in between.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; discards all buffered and in-flight words
//     s      wembley_stream_if slave modport (handshake, operands, serial output)
//   Functions (result truncated to WIDTH bits):
//     mode 0: (A & B) ^ C      mode 1: (A | B) & ~C
//     mode 2: bitwise majority mode 3: A + B + C
module wembley_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    wembley_stream_if.slave   s
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BC_W  = $clog2(WIDTH);

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [1:0]       mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] eval_fn(input word_t w);
        logic [WIDTH-1:0] r;
        case (w.mode)
            2'd0:    r = (w.a & w.b) ^ w.c;
            2'd1:    r = (w.a | w.b) & ~w.c;
            2'd2:    r = (w.a & w.b) | (w.a & w.c) | (w.b & w.c);
            default: r = w.a + w.b + w.c;
        endcase
        return r;
    endfunction

    word_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    state_t            state_q,  state_d;
    logic [WIDTH-1:0]  sr_q,     sr_d;
    logic [BC_W-1:0]   bc_q,     bc_d;

    logic  push;
    logic  pop;
    word_t in_word;

    assign in_word = '{mode: s.mode, a: s.Ain, b: s.Bin, c: s.Cin};

    // Input side: no push-through when full, even if a pop happens this edge.
    // Pop whenever the shifter is free, or on the last bit so the next word
    // starts on the following cycle without a gap.
    always_comb begin
        push     = s.in_valid && (count_q != CNT_FULL);
        pop      = (count_q != '0) && ((state_q == IDLE) || (bc_q == BC_LAST));

        state_d  = state_q;
        sr_d     = sr_q;
        bc_d     = bc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (state_q == SHIFT) begin
            sr_d = sr_q >> 1;
            bc_d = bc_q + BC_W'(1);
            if (bc_q == BC_LAST) begin
                state_d = IDLE;
            end
        end

        if (pop) begin
            sr_d     = eval_fn(mem_q[rd_ptr_q]);
            bc_d     = '0;
            state_d  = SHIFT;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bc_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bc_q     <= bc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    // Outputs decode registered state only; gated so Yout rests at 0.
    logic shifting;
    assign shifting  = (state_q == SHIFT);
    assign s.in_ready = (count_q != CNT_FULL);
    assign s.y_valid  = shifting;
    assign s.Yout     = shifting & sr_q[0];
    assign s.y_last   = shifting & (bc_q == BC_LAST);
    assign s.busy     = shifting | (count_q != '0);

endmodule

// File: tb/tb_wembley_stream.sv
module tb_wembley_stream;
    localparam int W = 8;
    localparam int D = 4;

    logic clk;
    logic reset;

    wembley_stream_if #(.WIDTH(W)) bus ();

    wembley_stream #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference function, written bit by bit from the function table.
    function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        int ones;
        int sum;
        r = '0;
        for (int i = 0; i < W; i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            case (m)
                2'd0:    r[i] = (a[i] & b[i]) ^ c[i];
                2'd1:    r[i] = (a[i] | b[i]) & ~c[i];
                2'd2:    r[i] = (ones >= 2);
                default: r[i] = 1'b0;
            endcase
        end
        if (m == 2'd3) begin
            sum = int'(a) + int'(b) + int'(c);
            r = W'(sum % (1 << W));
        end
        return r;
    endfunction

    logic [W-1:0] sb[$];

    // Output monitor: assembles serial words and compares against the scoreboard.
    int           bcnt     = 0;
    int           run_len  = 0;
    int           max_run  = 0;
    int           last_cnt = 0;
    logic [W-1:0] acc      = '0;
    logic [W-1:0] want_w;

    always @(negedge clk) begin
        if (reset) begin
            bcnt = 0;
            run_len = 0;
            sb.delete();
        end else if (bus.y_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            acc[bcnt] = bus.Yout;
            chk("mon_y_last_pos", 32'(bus.y_last), 32'(bcnt == W - 1));
            if (bcnt == W - 1) begin
                last_cnt++;
                if (sb.size() == 0) begin
                    chk("mon_unexpected_word", 32'(acc), 32'hFFFF_FFFF);
                end else begin
                    want_w = sb.pop_front();
                    chk("mon_word", 32'(acc), 32'(want_w));
                end
                bcnt = 0;
            end else begin
                bcnt++;
            end
        end else begin
            run_len = 0;
            chk("mon_idle_quiet", {30'd0, bus.Yout, bus.y_last}, 32'd0);
            if (bcnt != 0) chk("mon_partial_word", 32'(bcnt), 32'd0);
            bcnt = 0;
        end
    end

    // Present a word from posedge+1; returns #1 after the accepting edge.
    task automatic push_word(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, output int stalls);
        logic rdy;
        logic done;
        stalls = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode = m;
        bus.Ain = a;
        bus.Bin = b;
        bus.Cin = c;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) begin
                sb.push_back(model(m, a, b, c));
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) chk("push_timeout", 32'd0, 32'd1);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int k = 0; k < 500 && !idle; k++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        if (!idle) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Push into an idle block and check latency, every bit and framing.
    task automatic send_and_watch(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] c,
                                  input logic [W-1:0] expv);
        int st;
        @(posedge clk);
        #1;
        push_word(m, a, b, c, st);
        chk({tag, "_stall"}, 32'(st), 32'd0);
        @(negedge clk);
        chk({tag, "_pre_valid"}, 32'(bus.y_valid), 32'd0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk({tag, "_valid"}, 32'(bus.y_valid), 32'd1);
            chk({tag, "_bit"}, 32'(bus.Yout), 32'(expv[i]));
            chk({tag, "_last"}, 32'(bus.y_last), 32'(i == W - 1));
        end
        @(negedge clk);
        chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        chk({tag, "_valid_fall"}, 32'(bus.y_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    int stl[6];
    int lc0;
    logic [W-1:0] ra, rb, rc;

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode = 2'd0;
        bus.Ain = '0;
        bus.Bin = '0;
        bus.Cin = '0;
        #1;
        chk("rst_yout", 32'(bus.Yout), 32'd0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
        chk("rst_y_last", 32'(bus.y_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Function table, each word into an idle block.
        send_and_watch("m0", 2'd0, 8'hF0, 8'hCC, 8'h0F, 8'hCF);
        repeat (3) begin
            @(negedge clk);
            chk("gap_valid", 32'(bus.y_valid), 32'd0);
        end
        send_and_watch("m2", 2'd2, 8'hF0, 8'hCC, 8'hAA, 8'hE8);
        send_and_watch("m1", 2'd1, 8'h0F, 8'h30, 8'h11, 8'h2E);
        send_and_watch("m3", 2'd3, 8'hFF, 8'h01, 8'h01, 8'h01);

        // Mode travels with each word.
        @(posedge clk);
        #1;
        push_word(2'd3, 8'h5A, 8'h3C, 8'h99, stl[0]);
        push_word(2'd0, 8'h5A, 8'h3C, 8'h99, stl[1]);
        wait_idle();

        // Back-to-back: six words with in_valid held, FIFO fills on word 4.
        max_run = 0;
        lc0 = last_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = W'($urandom);
            push_word(2'(i % 4), ra, rb, rc, stl[i]);
            if (i < 5) bus.in_valid = 1'b1;
            if (i == 4) chk("b2b_full_ready", 32'(bus.in_ready), 32'd0);
        end
        for (int i = 0; i < 5; i++) chk("b2b_stall_w0to4", 32'(stl[i]), 32'd0);
        chk("b2b_stall_w5", 32'(stl[5]), 32'd5);
        wait_idle();
        chk("b2b_run_len", 32'(max_run), 32'(6 * W));
        chk("b2b_last_pulses", 32'(last_cnt - lc0), 32'd6);

        // Asynchronous reset during bit 3 with two words buffered.
        @(posedge clk);
        #1;
        push_word(2'd0, 8'hF0, 8'hCC, 8'h0F, stl[0]);
        push_word(2'd1, 8'hFF, 8'h00, 8'h00, stl[1]);
        push_word(2'd2, 8'hFF, 8'hFF, 8'h00, stl[2]);
        repeat (3) @(negedge clk);
        chk("rstmid_pre_valid", 32'(bus.y_valid), 32'd1);
        chk("rstmid_pre_bit3", 32'(bus.Yout), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid_yout", 32'(bus.Yout), 32'd0);
        chk("rstmid_y_valid", 32'(bus.y_valid), 32'd0);
        chk("rstmid_y_last", 32'(bus.y_last), 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        send_and_watch("post_rst", 2'd0, 8'h12, 8'h34, 8'h56, 8'h46);

        wait_idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
